hazard_forward_ctrl: RTL and testbench
======================================

Name: hazard_forward_ctrl

Overview:
- Pipeline hazard controller for the 5-stage ARM-subset CPU (IF, ID, EX, MEM, WB).
- Tracks in-flight destination registers in an internal shadow pipeline (EX, MEM and WB slots).
- Generates operand-forwarding mux selects for the ID-stage operands.
- Detects load-use hazards, inserts a one-cycle bubble, and produces the IF/ID flush on a taken branch or BL.
- Sits beside the decoder and drives the PC, IF/ID and ID/EX control-mux load/select lines.

Parameters:
- REG_W, 4: register-number width.
- PC_REG, 15: register number of the PC; never forwarded, never a hazard source.
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high reset.
- ID_rn  in  REG_W  first source register of the instruction in ID.
- ID_rm  in  REG_W  second source register.
- ID_rd_src  in  REG_W  store-data source register (STR).
- ID_use_rn, ID_use_rm, ID_use_rd  in  1 each  the corresponding source is actually read.
- ID_rd  in  REG_W  destination register of the ID instruction.
- ID_RF_enable  in  1  ID instruction writes the register file.
- ID_load_instr  in  1  ID instruction is a load.
- branch_taken  in  1  condition handler resolves B/BL taken in ID.
- fwd_rn_sel, fwd_rm_sel, fwd_rd_sel  out  2 each  00 = RF, 01 = EX, 10 = MEM, 11 = WB.
- PC_LE  out  1  PC load enable.
- IF_ID_LE  out  1  IF/ID register load enable.
- ID_nop_sel  out  1  selects all-zero control into ID/EX (bubble).
- IF_ID_flush  out  1  clears IF/ID on the next edge.
- stall_count  out  CNT_W  saturating count of stall cycles.

Behaviour:
Shadow slots
- Each slot (EX, MEM, WB) holds {valid, rd, rf_en, load}.
- On every clk edge: WB <= MEM, MEM <= EX.
- EX <= ID fields with valid=1, or valid=0 if a stall or reset is active.
- A slot matches a source register S when valid && rf_en && rd==S && S!=PC_REG.

Forwarding (combinational)
- For each used source, priority is EX > MEM > WB; select the first matching slot.
- If no slot matches, or the source is unused, the select is 00.

Load-use stall (combinational)
- stall = EX.valid && EX.load && EX.rf_en && EX.rd matches any used source (rn, rm or rd_src).
- While stall: PC_LE=0, IF_ID_LE=0, ID_nop_sel=1.
- Otherwise: PC_LE=1, IF_ID_LE=1, ID_nop_sel=0.
- Stall lasts exactly 1 cycle: next cycle the load is in MEM and the consumer forwards with select 10.
- While stalled, forwarding selects are still driven but ignored, since a bubble is issued.

Branch flush
- IF_ID_flush = branch_taken && !stall.
- stall together with branch_taken gives stall only: the branch itself is held in ID and re-resolves next cycle.
- The flush lasts a single cycle per taken branch (one cycle per cycle branch_taken is high without stall).

stall_count
- Increments on each clk edge where stall=1.
- Saturates at all-ones.

Reset (asynchronous, active-high)
- All slots go invalid, stall_count=0.
- While reset is high: PC_LE=0, IF_ID_LE=0, ID_nop_sel=1, IF_ID_flush=0, all selects 00.
- After release, the first cycle has PC_LE=1 and no forwarding.
- Reset mid-stall drops the pending load slot; no stall occurs after release.

Boundary conditions
- Destination equal to PC_REG never forwards or stalls.
- The same register pending in EX and MEM forwards from EX (youngest).
- A load in MEM or WB never stalls.
- A bubble slot (valid=0) never matches.

Decomposition:
- Shared package cpu_pkg:
  - REG_W and PC_REG constants.
  - Forward-select encodings FWD_RF, FWD_EX, FWD_MEM, FWD_WB.
  - Shadow-slot struct type.
- One natural sub-module: fwd_select, a combinational priority match of one source register against the three slots, instantiated three times.

Test Plan:
- ADD r1 then ADD r2,r1,r3 back-to-back -> fwd_rn_sel=01 in cycle 2, no stall.
- LDR r4 then ADD r5,r4,r4 -> one cycle with PC_LE=0, IF_ID_LE=0, ID_nop_sel=1, stall_count 0->1; next cycle fwd_rn_sel=fwd_rm_sel=10.
- Writes to r1 in three consecutive instructions, then a read of r1 -> select 01 (EX wins); with a bubble inserted, select 10.
- branch_taken=1 for one cycle with no hazard -> IF_ID_flush=1 for exactly one cycle; branch_taken coincident with a load-use stall -> IF_ID_flush=0, stall=1.
- Instruction writing r15 followed by a read of r15 -> all selects 00, no stall.
- Assert reset while a stall is pending -> outputs take reset values immediately; after release no stall, stall_count=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared register constants, forward-select encodings and the
// shadow-pipeline slot type for the 5-stage ARM-subset hazard logic.
//   REG_W      register-number width
//   PC_REG     register number of the PC (never forwarded, never a hazard)
//   fwd_sel_e  operand mux select: RF, EX, MEM or WB result
//   slot_t     one in-flight destination: {valid, rd, rf_en, load}
//   slot_hit   true when a slot will produce the value of register src
package cpu_pkg;

    localparam int REG_W  = 4;
    localparam int PC_REG = 15;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_sel_e;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             rf_en;
        logic             load;
    } slot_t;

    // The PC is read from the fetch path, so it never takes a forwarded value.
    function automatic logic slot_hit(slot_t s, logic [REG_W-1:0] src, logic [REG_W-1:0] pc);
        return s.valid && s.rf_en && s.rd == src && src != pc;
    endfunction

endpackage

// File: rtl/fwd_select.sv
// fwd_select: priority match of one ID source register against the shadow slots.
//   ex_i, mem_i, wb_i  shadow slots, youngest first
//   src_i              source register number
//   used_i             the instruction actually reads src_i
//   sel_o              forward select: youngest matching slot, else RF
module fwd_select
    import cpu_pkg::*;
#(
    parameter logic [REG_W-1:0] PC_NUM = REG_W'(PC_REG)
) (
    input  slot_t            ex_i,
    input  slot_t            mem_i,
    input  slot_t            wb_i,
    input  logic [REG_W-1:0] src_i,
    input  logic             used_i,
    output logic [1:0]       sel_o
);

    always_comb begin
        sel_o = !used_i                        ? FWD_RF  :
                slot_hit(ex_i, src_i, PC_NUM)  ? FWD_EX  :
                slot_hit(mem_i, src_i, PC_NUM) ? FWD_MEM :
                slot_hit(wb_i, src_i, PC_NUM)  ? FWD_WB  : FWD_RF;
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: forwarding, load-use stall and branch flush control
// for the 5-stage ARM-subset pipeline.
//   clk, reset                    pipeline clock, async active-high reset
//   ID_rn/ID_rm/ID_rd_src         ID-stage source registers
//   ID_use_rn/ID_use_rm/ID_use_rd each source is actually read
//   ID_rd, ID_RF_enable           ID destination and register-file write
//   ID_load_instr                 ID instruction is a load
//   branch_taken                  B/BL resolved taken in ID
//   fwd_rn_sel/rm_sel/rd_sel      operand mux selects (00 RF,01 EX,10 MEM,11 WB)
//   PC_LE, IF_ID_LE               PC and IF/ID load enables
//   ID_nop_sel                    inject a bubble into ID/EX
//   IF_ID_flush                   clear IF/ID on the next edge
//   stall_count                   saturating count of stall cycles
module hazard_forward_ctrl #(
    parameter int REG_W  = 4,
    parameter int PC_REG = 15,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] ID_rn,
    input  logic [REG_W-1:0] ID_rm,
    input  logic [REG_W-1:0] ID_rd_src,
    input  logic             ID_use_rn,
    input  logic             ID_use_rm,
    input  logic             ID_use_rd,
    input  logic [REG_W-1:0] ID_rd,
    input  logic             ID_RF_enable,
    input  logic             ID_load_instr,
    input  logic             branch_taken,
    output logic [1:0]       fwd_rn_sel,
    output logic [1:0]       fwd_rm_sel,
    output logic [1:0]       fwd_rd_sel,
    output logic             PC_LE,
    output logic             IF_ID_LE,
    output logic             ID_nop_sel,
    output logic             IF_ID_flush,
    output logic [CNT_W-1:0] stall_count
);

    import cpu_pkg::*;

    localparam logic [REG_W-1:0] PC_NUM = REG_W'(PC_REG);

    slot_t            ex_q, mem_q, wb_q, ex_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stall;

    // A load still in EX has no data yet; any consumer must wait one cycle
    // and then picks the value up from MEM.
    always_comb begin
        stall = ex_q.load && ((ID_use_rn && slot_hit(ex_q, ID_rn, PC_NUM)) ||
                              (ID_use_rm && slot_hit(ex_q, ID_rm, PC_NUM)) ||
                              (ID_use_rd && slot_hit(ex_q, ID_rd_src, PC_NUM)));
        ex_d = '{valid: !stall, rd: ID_rd, rf_en: ID_RF_enable, load: ID_load_instr};
        cnt_d = (stall && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
        PC_LE = !reset && !stall;
        IF_ID_LE = !reset && !stall;
        ID_nop_sel = reset || stall;
        // A stalled branch stays in ID and re-resolves, so it must not flush yet.
        IF_ID_flush = !reset && branch_taken && !stall;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
            cnt_q <= cnt_d;
        end
    end

    assign stall_count = cnt_q;

    fwd_select #(.PC_NUM(PC_NUM)) u_rn (
        .ex_i(ex_q), .mem_i(mem_q), .wb_i(wb_q),
        .src_i(ID_rn), .used_i(ID_use_rn), .sel_o(fwd_rn_sel)
    );

    fwd_select #(.PC_NUM(PC_NUM)) u_rm (
        .ex_i(ex_q), .mem_i(mem_q), .wb_i(wb_q),
        .src_i(ID_rm), .used_i(ID_use_rm), .sel_o(fwd_rm_sel)
    );

    fwd_select #(.PC_NUM(PC_NUM)) u_rd (
        .ex_i(ex_q), .mem_i(mem_q), .wb_i(wb_q),
        .src_i(ID_rd_src), .used_i(ID_use_rd), .sel_o(fwd_rd_sel)
    );

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb_hazard_forward_ctrl: scoreboard bench for hazard_forward_ctrl.
module tb_hazard_forward_ctrl;

    localparam logic [3:0] RUN = 4'b1100;
    localparam logic [3:0] STL = 4'b0010;
    localparam logic [3:0] FLS = 4'b1101;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  ID_rn = '0, ID_rm = '0, ID_rd_src = '0, ID_rd = '0;
    logic        ID_use_rn = 1'b0, ID_use_rm = 1'b0, ID_use_rd = 1'b0;
    logic        ID_RF_enable = 1'b0, ID_load_instr = 1'b0, branch_taken = 1'b0;
    logic [1:0]  fwd_rn_sel, fwd_rm_sel, fwd_rd_sel;
    logic        PC_LE, IF_ID_LE, ID_nop_sel, IF_ID_flush;
    logic [15:0] stall_count;

    typedef struct packed {
        logic [1:0]  rn;
        logic [1:0]  rm;
        logic [1:0]  rd;
        logic [3:0]  ctl;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    hazard_forward_ctrl dut (
        .clk(clk), .reset(reset),
        .ID_rn(ID_rn), .ID_rm(ID_rm), .ID_rd_src(ID_rd_src),
        .ID_use_rn(ID_use_rn), .ID_use_rm(ID_use_rm), .ID_use_rd(ID_use_rd),
        .ID_rd(ID_rd), .ID_RF_enable(ID_RF_enable), .ID_load_instr(ID_load_instr),
        .branch_taken(branch_taken),
        .fwd_rn_sel(fwd_rn_sel), .fwd_rm_sel(fwd_rm_sel), .fwd_rd_sel(fwd_rd_sel),
        .PC_LE(PC_LE), .IF_ID_LE(IF_ID_LE), .ID_nop_sel(ID_nop_sel),
        .IF_ID_flush(IF_ID_flush), .stall_count(stall_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic compare(input string tag);
        exp_t e;
        check({tag, " sb"}, 32'(sb.size()), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check({tag, " rn_sel"}, 32'(fwd_rn_sel), 32'(e.rn));
        check({tag, " rm_sel"}, 32'(fwd_rm_sel), 32'(e.rm));
        check({tag, " rd_sel"}, 32'(fwd_rd_sel), 32'(e.rd));
        check({tag, " ctl"}, 32'({PC_LE, IF_ID_LE, ID_nop_sel, IF_ID_flush}), 32'(e.ctl));
        check({tag, " cnt"}, 32'(stall_count), 32'(e.cnt));
    endtask

    // ctl = {PC_LE, IF_ID_LE, ID_nop_sel, IF_ID_flush}; uses = {rn, rm, rd_src}
    task automatic step(input string tag, input logic rst_v,
                        input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rds,
                        input logic [2:0] uses, input logic [3:0] rd,
                        input logic rfen, input logic ld, input logic br,
                        input logic [1:0] ern, input logic [1:0] erm, input logic [1:0] erd,
                        input logic [3:0] ectl, input logic [15:0] ecnt);
        @(posedge clk);
        #1;
        reset = rst_v;
        ID_rn = rn;
        ID_rm = rm;
        ID_rd_src = rds;
        {ID_use_rn, ID_use_rm, ID_use_rd} = uses;
        ID_rd = rd;
        ID_RF_enable = rfen;
        ID_load_instr = ld;
        branch_taken = br;
        sb.push_back('{ern, erm, erd, ectl, ecnt});
        @(negedge clk);
        compare(tag);
    endtask

    initial begin
        step("rst",      1,  1,  0,  0, 3'b100,  0, 0, 0, 1,  0, 0, 0, STL, 0);
        step("add_r1",   0,  0,  0,  0, 3'b000,  1, 1, 0, 0,  0, 0, 0, RUN, 0);
        step("fwd_ex",   0,  1,  3,  0, 3'b110,  2, 1, 0, 0,  1, 0, 0, RUN, 0);
        step("ldr_r4",   0,  0,  0,  0, 3'b000,  4, 1, 1, 0,  0, 0, 0, RUN, 0);
        step("lu_stall", 0,  4,  4,  0, 3'b110,  5, 1, 0, 0,  1, 1, 0, STL, 0);
        step("lu_mem",   0,  4,  4,  0, 3'b110,  5, 1, 0, 0,  2, 2, 0, RUN, 1);
        step("wb_r4",    0,  4,  0,  0, 3'b100,  1, 1, 0, 0,  3, 0, 0, RUN, 1);
        step("w1_b",     0,  0,  0,  0, 3'b000,  1, 1, 0, 0,  0, 0, 0, RUN, 1);
        step("w1_c",     0,  0,  0,  0, 3'b000,  1, 1, 0, 0,  0, 0, 0, RUN, 1);
        step("rd_ex",    0,  1,  5,  1, 3'b111,  0, 0, 0, 0,  1, 0, 1, RUN, 1);
        step("rd_mem",   0,  1,  0,  0, 3'b100,  0, 0, 0, 0,  2, 0, 0, RUN, 1);
        step("rd_wb",    0,  1,  0,  0, 3'b100,  0, 0, 0, 0,  3, 0, 0, RUN, 1);
        step("br",       0,  0,  0,  0, 3'b000,  0, 0, 0, 1,  0, 0, 0, FLS, 1);
        step("ldr_r6",   0,  0,  0,  0, 3'b000,  6, 1, 1, 0,  0, 0, 0, RUN, 1);
        step("br_stall", 0,  6,  0,  0, 3'b100,  0, 0, 0, 1,  1, 0, 0, STL, 1);
        step("br_go",    0,  6,  0,  0, 3'b100, 15, 1, 0, 1,  2, 0, 0, FLS, 2);
        step("pc_rd",    0, 15, 15, 15, 3'b111, 15, 1, 1, 0,  0, 0, 0, RUN, 2);
        step("pc_ld",    0, 15, 15, 15, 3'b111,  0, 0, 0, 0,  0, 0, 0, RUN, 2);
        step("ldr_r7",   0,  0,  0,  0, 3'b000,  7, 1, 1, 0,  0, 0, 0, RUN, 2);
        step("st_r7",    0,  7,  0,  0, 3'b100,  7, 1, 0, 0,  1, 0, 0, STL, 2);
        step("bubble",   0,  7,  0,  0, 3'b100,  7, 1, 0, 0,  2, 0, 0, RUN, 3);
        step("ldr_r8",   0,  0,  7,  0, 3'b010,  8, 1, 1, 0,  0, 1, 0, RUN, 3);
        step("st_r8",    0,  8,  0,  0, 3'b100,  0, 0, 0, 1,  1, 0, 0, STL, 3);
        // Reset lands mid-stall, between clock edges: outputs react at once.
        reset = 1'b1;
        #1;
        sb.push_back('{2'd0, 2'd0, 2'd0, STL, 16'd0});
        compare("async_rst");
        step("post_rst", 0,  8,  0,  0, 3'b100,  9, 1, 0, 0,  0, 0, 0, RUN, 0);
        step("post_fwd", 0,  9,  0,  0, 3'b100,  0, 0, 0, 0,  1, 0, 0, RUN, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
